grey_capture_ctrl: RTL and testbench

Sequences one greyscale frame capture. Arms on a start command, syncs to the next frame, counts sensor rows and columns and crops the active window out of the full frame. It packs two 8-bit grey pixels per 16-bit word and issues addressed writes to the frame buffer. It sits between the greyscale converter's registered output (grey pixel + delayed data-valid) and the frame-buffer write port.

---
 rtl/grey_capture_ctrl.sv | 140 ++++++++++++++
 tb/tb_grey_capture_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/grey_capture_ctrl.sv
// grey_capture_ctrl: arms on start, syncs to the next frame, crops the active window
// and packs pairs of 8-bit grey pixels into addressed frame-buffer writes.
module grey_capture_ctrl #(
    parameter int num_rows        = 32,
    parameter int num_cols        = 32,
    parameter int full_frame_rows = 36,
    parameter int full_frame_cols = 36,
    parameter int row_offset      = 2,
    parameter int col_offset      = 2,
    parameter int num_bits_rgb    = 12,
    parameter int output_width    = 16
) (
    input  logic                                      iclk,
    input  logic                                      irst_n,
    input  logic                                      istart,
    input  logic                                      icontinuous,
    input  logic                                      if_val,
    input  logic                                      id_val,
    input  logic [num_bits_rgb-1:0]                   igrey,
    input  logic                                      iwr_ready,
    output logic                                      owr_en,
    output logic [$clog2(num_rows*num_cols/2)-1:0]    owr_addr,
    output logic [output_width-1:0]                   owr_data,
    output logic                                      obusy,
    output logic                                      odone,
    output logic [1:0]                                ostatus,
    output logic [7:0]                                oframe_count
);
    localparam int AW = $clog2(num_rows*num_cols/2);
    localparam int RW = $clog2(full_frame_rows+1);
    localparam int CW = $clog2(full_frame_cols+1);
    localparam logic [RW-1:0] ROW_LO  = RW'(row_offset);
    localparam logic [RW-1:0] ROW_HI  = RW'(row_offset+num_rows);
    localparam logic [RW-1:0] ROW_MAX = RW'(full_frame_rows-1);
    localparam logic [CW-1:0] COL_LO  = CW'(col_offset);
    localparam logic [CW-1:0] COL_HI  = CW'(col_offset+num_cols);
    localparam logic [CW-1:0] COL_MAX = CW'(full_frame_cols-1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(num_rows*num_cols/2-1);

    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;

    state_t                  state_q, state_d;
    logic                    fval_q, half_q, half_d, pend_q, pend_d;
    logic [RW-1:0]           row_q, row_d, r;
    logic [CW-1:0]           col_q, col_d, c;
    logic [7:0]              hold_q, hold_d, pix, count_q, count_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic [output_width-1:0] data_q, data_d;
    logic [1:0]              status_q, status_d;
    logic                    rise, active, in_win, last_word, unused_lsb;

    assign pix        = igrey[num_bits_rgb-1 -: 8];
    assign unused_lsb = ^igrey[num_bits_rgb-9:0];
    // the rising-edge cycle already carries pixel (0,0), so it is counted with cleared counters
    assign rise      = state_q == ARM && !fval_q && if_val;
    assign active    = rise || (state_q == CAPTURE && if_val);
    assign r         = rise ? '0 : row_q;
    assign c         = rise ? '0 : col_q;
    assign in_win    = active && id_val && r >= ROW_LO && r < ROW_HI && c >= COL_LO && c < COL_HI;
    assign last_word = pend_q && addr_q == ADDR_LAST;

    always_comb begin
        state_d  = state_q;
        row_d    = r;
        col_d    = c;
        half_d   = half_q && !rise;
        hold_d   = hold_q;
        pend_d   = 1'b0;
        data_d   = data_q;
        addr_d   = rise ? '0 : addr_q;
        status_d = status_q;
        count_d  = count_q;
        if (active && id_val) begin
            col_d = c == COL_MAX ? '0 : c + 1'b1;
            row_d = (c == COL_MAX && r != ROW_MAX) ? r + 1'b1 : r;
        end
        if (in_win) begin
            hold_d = half_d ? hold_q : pix;
            pend_d = half_d;
            data_d = half_d ? output_width'({hold_q, pix}) : data_q;
            half_d = !half_d;
        end
        // a dropped word still consumes its address so the buffer layout stays fixed
        if (pend_q) begin
            addr_d      = last_word ? addr_q : addr_q + 1'b1;
            status_d[0] = status_q[0] | !iwr_ready;
        end
        case (state_q)
            IDLE: if (istart) begin
                state_d  = ARM;
                status_d = '0;
            end
            ARM: if (rise) state_d = CAPTURE;
            CAPTURE: if (last_word) begin
                state_d = DONE;
                count_d = count_q + 1'b1;
            end else if (!if_val) begin
                state_d     = DONE;
                status_d[1] = 1'b1;
            end
            default: state_d = icontinuous ? ARM : IDLE;
        endcase
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q  <= IDLE;
            fval_q   <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
            half_q   <= 1'b0;
            hold_q   <= '0;
            pend_q   <= 1'b0;
            data_q   <= '0;
            addr_q   <= '0;
            status_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            fval_q   <= if_val;
            row_q    <= row_d;
            col_q    <= col_d;
            half_q   <= half_d;
            hold_q   <= hold_d;
            pend_q   <= pend_d;
            data_q   <= data_d;
            addr_q   <= addr_d;
            status_q <= status_d;
            count_q  <= count_d;
        end
    end

    assign owr_en       = pend_q && iwr_ready;
    assign owr_addr     = addr_q;
    assign owr_data     = data_q;
    assign obusy        = state_q != IDLE;
    assign odone        = state_q == DONE;
    assign ostatus      = status_q;
    assign oframe_count = count_q;
endmodule

// File: tb/tb_grey_capture_ctrl.sv
// tb_grey_capture_ctrl: random-stimulus bench comparing the capture controller against a
// pixel-index model of the cropped, packed frame plus literal checks per scenario.
module tb_grey_capture_ctrl;
    logic        clk = 0, rst_n = 1, istart = 0, icont = 0, fval = 0, dval = 0, ready = 1;
    logic [11:0] grey = 0;
    logic        owr_en, obusy, odone;
    logic [8:0]  owr_addr;
    logic [15:0] owr_data;
    logic [1:0]  ostatus;
    logic [7:0]  ofc;

    grey_capture_ctrl dut (
        .iclk(clk), .irst_n(rst_n), .istart(istart), .icontinuous(icont),
        .if_val(fval), .id_val(dval), .igrey(grey), .iwr_ready(ready),
        .owr_en(owr_en), .owr_addr(owr_addr), .owr_data(owr_data), .obusy(obusy),
        .odone(odone), .ostatus(ostatus), .oframe_count(ofc)
    );

    always #5 clk = ~clk;

    int checks = 0, passed = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    endtask

    // model: frame position -> (row,col) -> window pixel index k -> word k/2
    int          m_st, m_pidx, m_paddr, m_words, slot_addr;
    bit          m_prev, m_pend, m_short, slot;
    logic [7:0]  m_hold, m_frames;
    logic [15:0] m_pdata;
    logic [1:0]  m_stat;

    task automatic take();
        int r, c, k;
        if (dval) begin
            r = m_pidx / 36;
            if (r > 35) r = 35;
            c = m_pidx % 36;
            if (r >= 2 && r < 34 && c >= 2 && c < 34) begin
                k = (r - 2) * 32 + (c - 2);
                if (k % 2 == 0) m_hold = grey[11:4];
                else begin
                    m_pend  = 1;
                    m_paddr = k / 2;
                    m_pdata = {m_hold, grey[11:4]};
                end
            end
            m_pidx++;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_st = 0; m_pidx = 0; m_paddr = 0; m_words = 0; m_prev = 0; m_pend = 0;
            m_short = 0; m_hold = 0; m_frames = 0; m_pdata = 0; m_stat = 0;
        end else begin
            slot = m_pend;
            slot_addr = m_paddr;
            if (slot) begin
                m_words = slot_addr + 1;
                if (!ready) m_stat[0] = 1;
            end
            m_pend = 0;
            case (m_st)
                0: if (istart) begin m_st = 1; m_stat = 0; end
                1: if (!m_prev && fval) begin
                    m_st = 2; m_pidx = 0; m_words = 0; m_short = 0;
                    take();
                end
                2: if (slot && slot_addr == 511) begin
                    m_st = 3; m_frames++;
                end else if (!fval) begin
                    m_st = 3; m_stat[1] = 1; m_short = 1;
                end else take();
                default: m_st = icont ? 1 : 0;
            endcase
            m_prev = fval;
        end
    end

    int          wr_cnt = 0, done_cnt = 0, idle_cyc = 0, cnt9 = 0, done_addr = 0;
    logic [15:0] w0 = 0, wlast = 0;

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("wr_en", owr_en, int'(m_pend && ready));
            if (m_pend) chk("wr_addr", owr_addr, m_paddr);
            if (m_pend && ready) chk("wr_data", owr_data, m_pdata);
            chk("busy", obusy, int'(m_st != 0));
            chk("done", odone, int'(m_st == 3));
            chk("status", ostatus, m_stat);
            chk("frames", ofc, m_frames);
            if (m_st == 3 && m_short) chk("short_addr", owr_addr, m_words);
            if (owr_en) begin
                wr_cnt++;
                if (owr_addr == 0) w0 = owr_data;
                if (owr_addr == 511) wlast = owr_data;
                if (owr_addr == 9) cnt9++;
            end
            if (odone) begin
                done_cnt++;
                done_addr = owr_addr;
            end
            if (!obusy) idle_cyc++;
        end
    end

    bit gap = 0, rand_pix = 0, rand_ready = 0, nxt_low = 0, rst_test = 0;
    int start_pix = -1, drop_word = -1;

    task automatic step(input bit f, input bit d, input bit st, input logic [11:0] g);
        fval = f; dval = d; istart = st; grey = g;
        ready = rand_ready ? ($urandom_range(0, 3) != 0) : !nxt_low;
        nxt_low = 0;
        @(posedge clk); #1;
    endtask

    task automatic blank(input int n);
        repeat (n) step(0, 0, 0, 12'($urandom));
    endtask

    task automatic frame(input int rows);
        int k;
        logic [3:0] rb, cb;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < 36; c++) begin
                rb = 4'(r);
                cb = 4'(c);
                if (gap && c % 2 == 0) step(1, 0, 0, 12'($urandom));
                step(1, 1, r * 36 + c == start_pix, rand_pix ? 12'($urandom) : {rb, cb, 4'h0});
                k = (r - 2) * 32 + (c - 2);
                if (r >= 2 && r < 34 && c >= 2 && c < 34 && k % 2 == 1 && k / 2 == drop_word) nxt_low = 1;
                if (rst_test && r == 8 && c == 11) begin
                    rst_n = 0; fval = 0; dval = 0;
                    #1;
                    chk("rst_wr_en", owr_en, 0);
                    chk("rst_addr", owr_addr, 0);
                    chk("rst_data", owr_data, 0);
                    chk("rst_busy", obusy, 0);
                    chk("rst_status", ostatus, 0);
                    chk("rst_frames", ofc, 0);
                    @(posedge clk); #1;
                    @(posedge clk); #1;
                    rst_n = 1;
                    @(posedge clk); #1;
                    rst_test = 0;
                    return;
                end
            end
        end
        fval = 0; dval = 0;
    endtask

    int w, d, i0;

    initial begin
        #2 rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_wr_en", owr_en, 0);
        chk("reset_addr", owr_addr, 0);
        chk("reset_data", owr_data, 0);
        chk("reset_busy", obusy, 0);
        chk("reset_done", odone, 0);
        chk("reset_status", ostatus, 0);
        chk("reset_frames", ofc, 0);
        rst_n = 1;
        @(posedge clk); #1;

        // full frame with the row/col pattern
        step(0, 0, 1, 0); blank(5);
        w = wr_cnt; d = done_cnt;
        frame(36); blank(10);
        chk("t1_writes", wr_cnt - w, 512);
        chk("t1_word0", w0, 16'h2223);
        chk("t1_last", wlast, 16'h1011);
        chk("t1_done_pulses", done_cnt - d, 1);
        chk("t1_frames", ofc, 1);
        chk("t1_status", ostatus, 0);
        chk("t1_idle", obusy, 0);

        // start mid-frame: that frame is skipped, the next one captured
        w = wr_cnt; start_pix = 500;
        frame(36);
        start_pix = -1;
        chk("t2_skipped", wr_cnt - w, 0);
        chk("t2_armed", obusy, 1);
        blank(8);
        rand_pix = 1; w = wr_cnt;
        frame(36); blank(10);
        chk("t2_writes", wr_cnt - w, 512);
        chk("t2_frames", ofc, 2);

        // one dropped word at address 9
        step(0, 0, 1, 0); blank(5);
        w = wr_cnt; d = cnt9; drop_word = 9;
        frame(36); blank(10);
        drop_word = -1;
        chk("t3_writes", wr_cnt - w, 511);
        chk("t3_addr9", cnt9 - d, 0);
        chk("t3_status", ostatus, 1);
        chk("t3_frames", ofc, 3);

        // short frame: if_val drops after 20 rows
        step(0, 0, 1, 0); blank(5);
        w = wr_cnt; d = done_cnt;
        frame(20); blank(10);
        chk("t4_writes", wr_cnt - w, 288);
        chk("t4_done_addr", done_addr, 288);
        chk("t4_done_pulses", done_cnt - d, 1);
        chk("t4_status", ostatus, 2);
        chk("t4_frames", ofc, 3);

        // continuous capture of three frames with id_val gaps
        icont = 1; gap = 1;
        step(0, 0, 1, 0); blank(5);
        w = wr_cnt; d = done_cnt; i0 = idle_cyc;
        frame(36); blank(5);
        frame(36); blank(5);
        chk("t5_busy_held", idle_cyc - i0, 0);
        icont = 0;
        frame(36); blank(10);
        gap = 0;
        chk("t5_writes", wr_cnt - w, 1536);
        chk("t5_done_pulses", done_cnt - d, 3);
        chk("t5_frames", ofc, 6);
        chk("t5_status", ostatus, 0);
        chk("t5_idle", obusy, 0);

        // random backpressure on a random image
        rand_ready = 1;
        step(0, 0, 1, 0); blank(5);
        frame(36); blank(10);
        rand_ready = 0;
        chk("t6_frames", ofc, 7);

        // reset in the middle of word 100, then no capture without a new start
        step(0, 0, 1, 0); blank(5);
        rst_test = 1;
        frame(36); blank(10);
        w = wr_cnt;
        frame(36); blank(10);
        chk("t7_no_writes", wr_cnt - w, 0);
        chk("t7_idle", obusy, 0);
        chk("t7_frames", ofc, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
